// File: rtl/sdram_dmem_reader.sv
// sdram_dmem_reader: copies SDRAM words [start_addr..end_addr] from the read FIFO into byte-wide DMEM.
// Latency: start -> REQ -> (grant) LOAD -> STREAM; each popped word gives two DMEM byte writes, low byte first.
// Backpressure: pops stall while fifo_empty=1 or trxn_grant=0; at most one pop every two cycles.
module sdram_dmem_reader #(
  parameter int SDRAM_A_LEN = 25,
  parameter int DMEM_A_LEN  = 14,
  parameter int DATA_W      = 16
) (
  input  logic                   ref_clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SDRAM_A_LEN-1:0] start_addr,
  input  logic [SDRAM_A_LEN-1:0] end_addr,
  input  logic [DMEM_A_LEN-1:0]  dmem_base,
  output logic                   trxn_req,
  input  logic                   trxn_grant,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   rd_load,
  output logic [SDRAM_A_LEN-1:0] rd_addr,
  output logic                   fifo_rd,
  input  logic                   fifo_empty,
  input  logic [DATA_W-1:0]      fifo_rd_data,
  output logic [DMEM_A_LEN-1:0]  dmem_addr,
  output logic [7:0]             dmem_wr_data,
  output logic                   dmem_wren
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_LOAD, S_STREAM, S_DONE} state_t;

  state_t                 state_q;
  logic                   trxn_req_q, busy_q, done_q, err_q, rd_load_q;
  logic [SDRAM_A_LEN-1:0] rd_addr_q;
  // One extra bit so a full-range transfer (2^SDRAM_A_LEN words) is representable.
  logic [SDRAM_A_LEN:0]   words_left_q, words_left_d;
  logic [DMEM_A_LEN-1:0]  ptr_q, ptr_d;
  logic [7:0]             hold_q, hold_d;
  logic                   rd_del_q, hi_pend_q;
  logic                   accept, pop, byte_wr;

  // A start is taken only from IDLE and only for a non-inverted range.
  assign accept  = (state_q == S_IDLE) && start && (end_addr >= start_addr);
  // Pops are spaced by rd_del_q so the low-byte cycle never overlaps a new FIFO read.
  assign pop     = (state_q == S_STREAM) && trxn_grant && !fifo_empty &&
                   (words_left_q != '0) && !rd_del_q;
  assign byte_wr = rd_del_q || hi_pend_q;

  assign fifo_rd      = pop;
  assign dmem_wren    = byte_wr;
  assign dmem_addr    = ptr_q;
  // Low byte comes straight from the FIFO output in the cycle after the pop; high byte from hold.
  assign dmem_wr_data = rd_del_q ? fifo_rd_data[7:0] : hold_q;

  assign trxn_req = trxn_req_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign rd_load  = rd_load_q;
  assign rd_addr  = rd_addr_q;

  // Next-state for the word counter, DMEM pointer and high-byte hold register.
  always_comb begin
    words_left_d = words_left_q;
    ptr_d        = ptr_q;
    hold_d       = hold_q;
    if (accept) begin
      words_left_d = {1'b0, end_addr} - {1'b0, start_addr} + (SDRAM_A_LEN+1)'(1);
      ptr_d        = dmem_base;
    end else begin
      if (pop)     words_left_d = words_left_q - (SDRAM_A_LEN+1)'(1);
      if (byte_wr) ptr_d        = ptr_q + DMEM_A_LEN'(1);
    end
    if (rd_del_q) hold_d = fifo_rd_data[15:8];
  end

  // Datapath registers: counter, pointer (wraps naturally), hold and the two byte-phase flags.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      words_left_q <= '0;
      ptr_q        <= '0;
      hold_q       <= '0;
      rd_del_q     <= 1'b0;
      hi_pend_q    <= 1'b0;
    end else begin
      words_left_q <= words_left_d;
      ptr_q        <= ptr_d;
      hold_q       <= hold_d;
      rd_del_q     <= pop;
      hi_pend_q    <= rd_del_q;
    end
  end

  // Control FSM with registered status/handshake outputs.
  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      trxn_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_load_q  <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rd_load_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            state_q    <= S_REQ;
            rd_addr_q  <= start_addr;
            trxn_req_q <= 1'b1;
            busy_q     <= 1'b1;
          end else if (start) begin
            err_q <= 1'b1;
          end
        end
        S_REQ: begin
          if (trxn_grant) begin
            state_q   <= S_LOAD;
            rd_load_q <= 1'b1;
          end
        end
        S_LOAD: begin
          state_q <= S_STREAM;
        end
        S_STREAM: begin
          // Finish only once every popped word has had both its bytes written.
          if ((words_left_q == '0) && !rd_del_q && !hi_pend_q) begin
            state_q    <= S_DONE;
            done_q     <= 1'b1;
            trxn_req_q <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_dmem_reader.sv
// tb_sdram_dmem_reader: drives SDRAM-read-to-DMEM transfers against a queue FIFO and an arbiter.
// Expected DMEM contents come from a word list split into low/high bytes at base+2i / base+2i+1.
// Handshake rules (pop spacing, empty, grant, req, done, err) are tallied per cycle on the falling edge.
module tb_sdram_dmem_reader;

  logic        ref_clk;
  logic        rst;
  logic        start;
  logic [24:0] start_addr, end_addr;
  logic [13:0] dmem_base;
  logic        trxn_req, trxn_grant, busy, done, err, rd_load;
  logic [24:0] rd_addr;
  logic        fifo_rd, fifo_empty;
  logic [15:0] fifo_rd_data;
  logic [13:0] dmem_addr;
  logic [7:0]  dmem_wr_data;
  logic        dmem_wren;

  int checks = 0;
  int failures = 0;

  // FIFO model state
  logic [15:0] fifo_q[$];
  int          fifo_cnt = 0;
  logic        force_empty = 1'b0;
  assign fifo_empty = force_empty || (fifo_cnt == 0);

  // Per-transfer observations
  int          cyc = 0, pops, loads, dones, errs, req_cyc, busy_cyc;
  int          b2b_err, empty_err, req_drop_err, last_pop;
  logic [24:0] load_addr;
  logic        prev_req = 1'b0;
  int          pop_cyc[$];
  logic [13:0] wr_addr[$];
  logic [7:0]  wr_dat[$];

  // Reference data
  logic [15:0] words[$];
  logic [13:0] exp_addr[$];
  logic [7:0]  exp_dat[$];

  // Window snapshots
  int ew_pops, ew_wr, dp_pops, dp_wr;

  sdram_dmem_reader dut (
    .ref_clk(ref_clk), .rst(rst), .start(start), .start_addr(start_addr), .end_addr(end_addr),
    .dmem_base(dmem_base), .trxn_req(trxn_req), .trxn_grant(trxn_grant), .busy(busy), .done(done),
    .err(err), .rd_load(rd_load), .rd_addr(rd_addr), .fifo_rd(fifo_rd), .fifo_empty(fifo_empty),
    .fifo_rd_data(fifo_rd_data), .dmem_addr(dmem_addr), .dmem_wr_data(dmem_wr_data),
    .dmem_wren(dmem_wren)
  );

  initial begin
    ref_clk = 1'b0;
    forever #5 ref_clk = ~ref_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Observe on the falling edge; commit FIFO pops just after the rising edge.
  initial begin : monitor
    bit pop_pend;
    forever begin
      @(negedge ref_clk);
      cyc++;
      pop_pend = fifo_rd;
      if (fifo_rd) begin
        pops++;
        if (cyc == last_pop + 1) b2b_err++;
        last_pop = cyc;
        pop_cyc.push_back(cyc);
        if (fifo_empty) empty_err++;
      end
      if (dmem_wren) begin
        wr_addr.push_back(dmem_addr);
        wr_dat.push_back(dmem_wr_data);
      end
      if (rd_load) begin loads++; load_addr = rd_addr; end
      if (done) dones++;
      if (err) errs++;
      if (trxn_req) req_cyc++;
      if (busy) busy_cyc++;
      if (prev_req && !trxn_req && !done && !rst) req_drop_err++;
      prev_req = trxn_req;
      @(posedge ref_clk);
      #1;
      if (pop_pend && fifo_q.size() > 0) begin
        fifo_rd_data = fifo_q.pop_front();
        fifo_cnt = fifo_q.size();
      end
    end
  end

  task automatic tick();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic clear_mon();
    pops = 0; loads = 0; dones = 0; errs = 0; req_cyc = 0; busy_cyc = 0;
    b2b_err = 0; empty_err = 0; req_drop_err = 0; last_pop = -10; load_addr = '0;
    pop_cyc.delete(); wr_addr.delete(); wr_dat.delete();
    ew_pops = -1; ew_wr = -1; dp_pops = -1; dp_wr = -1;
  endtask

  // Reference: word i lands as low byte at base+2i and high byte at base+2i+1, modulo 2^14.
  function automatic void build_exp(input int b);
    exp_addr.delete(); exp_dat.delete();
    for (int i = 0; i < words.size(); i++) begin
      logic [15:0] w;
      w = words[i];
      exp_addr.push_back(14'((b + 2*i) % 16384));
      exp_dat.push_back(w[7:0]);
      exp_addr.push_back(14'((b + 2*i + 1) % 16384));
      exp_dat.push_back(w[15:8]);
    end
  endfunction

  // One transfer: loads the FIFO with 'words', pulses start, plays arbiter until done.
  task automatic run_xfer(input logic [24:0] s, input logic [24:0] e, input logic [13:0] b,
                          input int empty_n, input int drop_after, input bit rnd,
                          input bit busy_start, output bit tmo);
    bit req_d, dropped, dp_taken, bs_done, ew_taken;
    int drop_left, dp_p0, dp_w0, since_load;
    clear_mon();
    build_exp(int'(b));
    foreach (words[i]) fifo_q.push_back(words[i]);
    fifo_cnt = fifo_q.size();
    start_addr = s; end_addr = e; dmem_base = b;
    force_empty = (empty_n > 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tmo = 1'b1; req_d = 1'b0; dropped = 1'b0; dp_taken = 1'b0; bs_done = 1'b0; ew_taken = 1'b0;
    drop_left = 0; dp_p0 = 0; dp_w0 = 0; since_load = 0;
    for (int k = 0; k < 3000; k++) begin
      start = 1'b0;
      if (busy_start && !bs_done && pops == 1) begin
        start = 1'b1; start_addr = 25'h0; end_addr = 25'h1FFFFFF; dmem_base = 14'h1234;
        bs_done = 1'b1;
      end
      if (empty_n > 0 && !ew_taken && loads > 0) begin
        since_load++;
        if (since_load > empty_n) begin
          ew_taken = 1'b1; ew_pops = pops; ew_wr = wr_addr.size(); force_empty = 1'b0;
        end
      end
      if (drop_after > 0 && !dropped && pops >= drop_after) begin
        dropped = 1'b1; drop_left = 5; dp_p0 = pops; dp_w0 = wr_addr.size();
      end
      if (drop_left > 0) begin
        trxn_grant = 1'b0;
        drop_left--;
      end else begin
        if (dropped && !dp_taken) begin
          dp_taken = 1'b1; dp_pops = pops - dp_p0; dp_wr = wr_addr.size() - dp_w0;
        end
        trxn_grant = rnd ? (trxn_req && req_d && ($urandom_range(0, 3) != 0)) : (trxn_req && req_d);
        if (rnd) force_empty = ($urandom_range(0, 3) == 0);
      end
      req_d = trxn_req;
      tick();
      if (dones > 0) begin tmo = 1'b0; break; end
    end
    start = 1'b0; trxn_grant = 1'b0; force_empty = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; trxn_grant = 1'b0; start_addr = '0; end_addr = '0; dmem_base = '0;
    fifo_rd_data = '0;
    tick(); tick();
    checks++; if ({trxn_req, busy, done, err, rd_load, fifo_rd, dmem_wren} !== 7'b0) begin failures++; $display("FAIL reset_ctrl got=%b want=0000000", {trxn_req, busy, done, err, rd_load, fifo_rd, dmem_wren}); end
    checks++; if (rd_addr !== 25'h0) begin failures++; $display("FAIL reset_rd_addr got=%h want=0", rd_addr); end
    checks++; if (dmem_addr !== 14'h0) begin failures++; $display("FAIL reset_dmem_addr got=%h want=0", dmem_addr); end
    checks++; if (dmem_wr_data !== 8'h0) begin failures++; $display("FAIL reset_wr_data got=%h want=0", dmem_wr_data); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit tmo;
    words = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
    run_xfer(25'h10, 25'h13, 14'h0, 0, 0, 1'b0, 1'b0, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%0d want=0", tmo); end
    checks++; if (loads !== 1) begin failures++; $display("FAIL basic_loads got=%0d want=1", loads); end
    checks++; if (load_addr !== 25'h10) begin failures++; $display("FAIL basic_rd_addr got=%h want=10", load_addr); end
    checks++; if (pops !== 4) begin failures++; $display("FAIL basic_pops got=%0d want=4", pops); end
    for (int i = 1; i < pop_cyc.size(); i++) begin
      checks++; if (pop_cyc[i] - pop_cyc[i-1] !== 2) begin failures++; $display("FAIL basic_pop_gap[%0d] got=%0d want=2", i, pop_cyc[i] - pop_cyc[i-1]); end
    end
    checks++; if (wr_addr.size() !== 8) begin failures++; $display("FAIL basic_nwr got=%0d want=8", wr_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      checks++; if (wr_addr[i] !== exp_addr[i] || wr_dat[i] !== exp_dat[i]) begin failures++; $display("FAIL basic_byte[%0d] got=%h@%h want=%h@%h", i, wr_dat[i], wr_addr[i], exp_dat[i], exp_addr[i]); end
    end
    checks++; if (dones !== 1) begin failures++; $display("FAIL basic_done got=%0d want=1", dones); end
    checks++; if (b2b_err + empty_err !== 0) begin failures++; $display("FAIL basic_pop_rules got=%0d want=0", b2b_err + empty_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_fifo_empty();
    bit tmo;
    words = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
    run_xfer(25'h200, 25'h203, 14'h40, 10, 0, 1'b0, 1'b0, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL empty_timeout got=%0d want=0", tmo); end
    checks++; if (ew_pops !== 0) begin failures++; $display("FAIL empty_window_pops got=%0d want=0", ew_pops); end
    checks++; if (ew_wr !== 0) begin failures++; $display("FAIL empty_window_wren got=%0d want=0", ew_wr); end
    checks++; if (wr_addr.size() !== 8) begin failures++; $display("FAIL empty_nwr got=%0d want=8", wr_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      checks++; if (wr_addr[i] !== exp_addr[i] || wr_dat[i] !== exp_dat[i]) begin failures++; $display("FAIL empty_byte[%0d] got=%h@%h want=%h@%h", i, wr_dat[i], wr_addr[i], exp_dat[i], exp_addr[i]); end
    end
    checks++; if (dones !== 1 || empty_err !== 0) begin failures++; $display("FAIL empty_done_rules got=%0d/%0d want=1/0", dones, empty_err); end
  endtask

  task automatic test_grant_drop();
    bit tmo;
    words = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
    run_xfer(25'h10, 25'h13, 14'h0, 0, 2, 1'b0, 1'b0, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL drop_timeout got=%0d want=0", tmo); end
    checks++; if (dp_pops !== 0) begin failures++; $display("FAIL drop_window_pops got=%0d want=0", dp_pops); end
    checks++; if (dp_wr !== 2) begin failures++; $display("FAIL drop_window_wren got=%0d want=2", dp_wr); end
    checks++; if (req_drop_err !== 0) begin failures++; $display("FAIL drop_req_held got=%0d want=0", req_drop_err); end
    checks++; if (wr_addr.size() !== 8 || pops !== 4) begin failures++; $display("FAIL drop_counts got=%0d/%0d want=8/4", wr_addr.size(), pops); end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      checks++; if (wr_addr[i] !== exp_addr[i] || wr_dat[i] !== exp_dat[i]) begin failures++; $display("FAIL drop_byte[%0d] got=%h@%h want=%h@%h", i, wr_dat[i], wr_addr[i], exp_dat[i], exp_addr[i]); end
    end
  endtask

  task automatic test_err();
    clear_mon();
    start_addr = 25'd5; end_addr = 25'd4; dmem_base = 14'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++; if (errs !== 1) begin failures++; $display("FAIL err_pulse got=%0d want=1", errs); end
    checks++; if (req_cyc !== 0 || busy_cyc !== 0) begin failures++; $display("FAIL err_req_busy got=%0d/%0d want=0/0", req_cyc, busy_cyc); end
    checks++; if (loads !== 0) begin failures++; $display("FAIL err_loads got=%0d want=0", loads); end
  endtask

  task automatic test_wrap();
    bit tmo;
    words = '{16'h55AA};
    run_xfer(25'h77, 25'h77, 14'h3FFF, 0, 0, 1'b0, 1'b0, tmo);
    checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL wrap_timeout got=%0d want=0", tmo); end
    checks++; if (wr_addr.size() !== 2) begin failures++; $display("FAIL wrap_nwr got=%0d want=2", wr_addr.size()); end
    if (wr_addr.size() >= 2) begin
      checks++; if (wr_addr[0] !== 14'h3FFF || wr_dat[0] !== 8'hAA) begin failures++; $display("FAIL wrap_lo got=%h@%h want=aa@3fff", wr_dat[0], wr_addr[0]); end
      checks++; if (wr_addr[1] !== 14'h0000 || wr_dat[1] !== 8'h55) begin failures++; $display("FAIL wrap_hi got=%h@%h want=55@0000", wr_dat[1], wr_addr[1]); end
    end
  endtask

  task automatic test_rst_mid();
    bit tmo, reached;
    clear_mon();
    words = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718};
    foreach (words[i]) fifo_q.push_back(words[i]);
    fifo_cnt = fifo_q.size();
    start_addr = 25'h10; end_addr = 25'h13; dmem_base = 14'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 200; k++) begin
      trxn_grant = trxn_req;
      tick();
      if (pops >= 2) begin reached = 1'b1; break; end
    end
    checks++; if (reached !== 1'b1) begin failures++; $display("FAIL rst_mid_reach got=%0d want=1", reached); end
    rst = 1'b1;
    #1;
    checks++; if ({trxn_req, busy, done, err, rd_load, fifo_rd, dmem_wren} !== 7'b0) begin failures++; $display("FAIL rst_mid_ctrl got=%b want=0000000", {trxn_req, busy, done, err, rd_load, fifo_rd, dmem_wren}); end
    checks++; if (rd_addr !== 25'h0 || dmem_addr !== 14'h0 || dmem_wr_data !== 8'h0) begin failures++; $display("FAIL rst_mid_data got=%h/%h/%h want=0/0/0", rd_addr, dmem_addr, dmem_wr_data); end
    trxn_grant = 1'b0;
    tick(); tick();
    rst = 1'b0;
    fifo_q.delete(); fifo_cnt = 0;
    tick();
    run_xfer(25'h10, 25'h13, 14'h0, 0, 0, 1'b0, 1'b0, tmo);
    checks++; if (tmo !== 1'b0 || dones !== 1 || loads !== 1) begin failures++; $display("FAIL rst_after got=%0d/%0d/%0d want=0/1/1", tmo, dones, loads); end
    checks++; if (wr_addr.size() !== 8) begin failures++; $display("FAIL rst_after_nwr got=%0d want=8", wr_addr.size()); end
    for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
      checks++; if (wr_addr[i] !== exp_addr[i] || wr_dat[i] !== exp_dat[i]) begin failures++; $display("FAIL rst_after_byte[%0d] got=%h@%h want=%h@%h", i, wr_dat[i], wr_addr[i], exp_dat[i], exp_addr[i]); end
    end
  endtask

  task automatic test_random();
    bit tmo;
    int n;
    logic [24:0] s;
    logic [13:0] b;
    for (int it = 0; it < 8; it++) begin
      n = $urandom_range(1, 6);
      s = 25'($urandom_range(0, 32'h1FFFF00));
      b = 14'($urandom);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
      run_xfer(s, s + 25'(n - 1), b, 0, 0, 1'b1, (it % 2) == 1, tmo);
      checks++; if (tmo !== 1'b0 || dones !== 1) begin failures++; $display("FAIL rand%0d_done got=%0d/%0d want=0/1", it, tmo, dones); end
      checks++; if (loads !== 1 || load_addr !== s || rd_addr !== s) begin failures++; $display("FAIL rand%0d_load got=%0d/%h/%h want=1/%h", it, loads, load_addr, rd_addr, s); end
      checks++; if (pops !== n || wr_addr.size() !== 2*n) begin failures++; $display("FAIL rand%0d_counts got=%0d/%0d want=%0d/%0d", it, pops, wr_addr.size(), n, 2*n); end
      checks++; if (b2b_err !== 0 || empty_err !== 0 || req_drop_err !== 0) begin failures++; $display("FAIL rand%0d_rules got=%0d/%0d/%0d want=0/0/0", it, b2b_err, empty_err, req_drop_err); end
      for (int i = 0; i < exp_addr.size() && i < wr_addr.size(); i++) begin
        checks++; if (wr_addr[i] !== exp_addr[i] || wr_dat[i] !== exp_dat[i]) begin failures++; $display("FAIL rand%0d_byte[%0d] got=%h@%h want=%h@%h", it, i, wr_dat[i], wr_addr[i], exp_dat[i], exp_addr[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_empty();
    test_grant_drop();
    test_err();
    test_wrap();
    test_rst_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
